// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 Set-2 scan-code filter: parser states,
// prefix and status byte values, and the Pause sequence length.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } ps2_state_e;

    // Prefix bytes
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    // Device status / reply bytes that never describe a key
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    // Bytes following E1 in the Pause make sequence (E1 14 77 E1 F0 14 F0 77)
    localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

    function automatic logic is_status_byte(input logic [7:0] b);
        return (b == PS2_BAT_OK) || (b == PS2_ACK)  || (b == PS2_RESEND) ||
               (b == PS2_ECHO)   || (b == PS2_ERR0) || (b == PS2_ERR1);
    endfunction

endpackage

// File: rtl/ps2_scan_filter_if.sv
// Byte stream in from the PS/2 controller, key events out to the decoder.
// master = byte source / event consumer, slave = the filter.
interface ps2_scan_filter_if #(
    parameter int HELD_DEPTH = 4
);
    logic [7:0]                          rx_data;
    logic                                rx_valid;
    logic [7:0]                          key_code;
    logic                                key_ext;
    logic                                key_make;
    logic                                key_break;
    logic [$clog2(HELD_DEPTH+1)-1:0]     held_count;
    logic                                held_ovf;

    modport master (
        output rx_data, rx_valid,
        input  key_code, key_ext, key_make, key_break, held_count, held_ovf
    );

    modport slave (
        input  rx_data, rx_valid,
        output key_code, key_ext, key_make, key_break, held_count, held_ovf
    );
endinterface

// File: rtl/ps2_held_table.sv
// Table of currently held keys, tagged by {ext, code}. Lookup is
// combinational; insert goes to the lowest free slot, remove clears any
// matching entry. Updates are visible on the following cycle.
module ps2_held_table #(
    parameter int HELD_DEPTH = 4
) (
    input  logic                              CLOCK_50,
    input  logic                              resetn,
    input  logic [8:0]                        lookup_tag_i,
    output logic                              hit_o,
    input  logic                              insert_i,
    input  logic                              remove_i,
    output logic [$clog2(HELD_DEPTH+1)-1:0]   count_o,
    output logic                              full_o
);
    localparam int CNT_W = $clog2(HELD_DEPTH + 1);

    logic                  valid_q [HELD_DEPTH];
    logic [8:0]            tag_q   [HELD_DEPTH];
    logic [HELD_DEPTH-1:0] match;
    logic [HELD_DEPTH-1:0] free_sel;
    logic                  found;

    // Per-entry tag comparison
    for (genvar gi = 0; gi < HELD_DEPTH; gi++) begin : g_match
        assign match[gi] = valid_q[gi] && (tag_q[gi] == lookup_tag_i);
    end

    assign hit_o = |match;

    // Lowest free slot (one-hot), occupancy count and full flag
    always_comb begin
        free_sel = '0;
        found    = 1'b0;
        count_o  = '0;
        full_o   = 1'b1;
        for (int i = 0; i < HELD_DEPTH; i++) begin
            count_o = count_o + CNT_W'(valid_q[i]);
            if (!valid_q[i]) begin
                full_o = 1'b0;
                if (!found) begin
                    free_sel[i] = 1'b1;
                    found       = 1'b1;
                end
            end
        end
    end

    // Entry storage: insert into the selected free slot, remove on tag match
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < HELD_DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= 9'h000;
            end
        end else begin
            for (int i = 0; i < HELD_DEPTH; i++) begin
                if (insert_i && free_sel[i]) begin
                    valid_q[i] <= 1'b1;
                    tag_q[i]   <= lookup_tag_i;
                end else if (remove_i && match[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/ps2_scan_filter.sv
// PS/2 Set-2 byte stream to key make/break events. Strips E0/F0/E1 prefixes
// and status bytes, abandons stalled prefix sequences after PREFIX_TIMEOUT
// cycles. Define PS2_TYPEMATIC_SUPPRESS_EN to build the held-key table that
// suppresses typematic repeats; otherwise every make pulses key_make.
module ps2_scan_filter
    import ps2_pkg::*;
#(
    parameter int HELD_DEPTH     = 4,
    parameter int PREFIX_TIMEOUT = 2_500_000
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    ps2_scan_filter_if.slave   bus
);
    localparam int CNT_W = $clog2(HELD_DEPTH + 1);
    localparam int TMO_W = $clog2(PREFIX_TIMEOUT + 1);

    ps2_state_e        state_q, state_d;
    logic [2:0]        skip_q, skip_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [7:0]        key_code_q;
    logic              key_ext_q, key_make_q, key_break_q;

    logic              ev_make, ev_break, ev_ext;
    logic [7:0]        ev_code;
    logic              make_fire;

    // Parser: next state, skip/timeout counters and raw event decode
    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        tmo_d    = tmo_q;
        ev_make  = 1'b0;
        ev_break = 1'b0;
        ev_ext   = 1'b0;
        ev_code  = bus.rx_data;
        if (bus.rx_valid) begin
            // A byte always wins over a coincident timeout
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.rx_data == PS2_EXT) begin
                        state_d = ST_EXT;
                    end else if (bus.rx_data == PS2_BRK) begin
                        state_d = ST_BRK;
                    end else if (bus.rx_data == PS2_PAUSE) begin
                        state_d = ST_SKIP;
                        skip_d  = PS2_PAUSE_SKIP;
                    end else if (!is_status_byte(bus.rx_data)) begin
                        ev_make = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (bus.rx_data == PS2_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (bus.rx_data != PS2_EXT) begin
                        ev_make = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    ev_break = 1'b1;
                    state_d  = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    ev_break = 1'b1;
                    ev_ext   = 1'b1;
                    state_d  = ST_IDLE;
                end
                ST_SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q <= 3'd1) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TMO_W'(PREFIX_TIMEOUT - 1)) begin
                state_d = ST_IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    // Parser state registers
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            skip_q  <= 3'd0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            tmo_q   <= tmo_d;
        end
    end

`ifdef PS2_TYPEMATIC_SUPPRESS_EN
    logic              held_hit, held_full;
    logic [CNT_W-1:0]  held_cnt;
    logic              held_ovf_q, held_ovf_d;

    ps2_held_table #(
        .HELD_DEPTH (HELD_DEPTH)
    ) u_held_table (
        .CLOCK_50     (CLOCK_50),
        .resetn       (resetn),
        .lookup_tag_i ({ev_ext, ev_code}),
        .hit_o        (held_hit),
        .insert_i     (ev_make && !held_hit && !held_full),
        .remove_i     (ev_break),
        .count_o      (held_cnt),
        .full_o       (held_full)
    );

    // A make of a key already held is a typematic repeat
    assign make_fire  = ev_make && !held_hit;
    assign held_ovf_d = held_ovf_q || (make_fire && held_full);

    // Sticky overflow flag
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            held_ovf_q <= 1'b0;
        end else begin
            held_ovf_q <= held_ovf_d;
        end
    end

    assign bus.held_count = held_cnt;
    assign bus.held_ovf   = held_ovf_q;
`else
    assign make_fire      = ev_make;
    assign bus.held_count = {CNT_W{1'b0}};
    assign bus.held_ovf   = 1'b0;
`endif

    // Event outputs: pulses for one cycle, code/ext held until the next event
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            key_code_q  <= 8'h00;
            key_ext_q   <= 1'b0;
            key_make_q  <= 1'b0;
            key_break_q <= 1'b0;
        end else begin
            key_make_q  <= make_fire;
            key_break_q <= ev_break;
            if (make_fire || ev_break) begin
                key_code_q <= ev_code;
                key_ext_q  <= ev_ext;
            end
        end
    end

    assign bus.key_code  = key_code_q;
    assign bus.key_ext   = key_ext_q;
    assign bus.key_make  = key_make_q;
    assign bus.key_break = key_break_q;

endmodule

// File: doc/ps2_scan_filter.md
# ps2_scan_filter

Sits directly between `PS2_Controller` and the blackjack key decoder. It turns the raw PS/2 Set-2 byte stream into clean key events, one per event:
- strips `0xE0`, `0xF0` and `0xE1` prefixes and device status bytes;
- separates make from break;
- with repeat suppression compiled in, suppresses typematic repeats of held keys.

The decoder then sees exactly one `key_make` pulse per physical press, so H/S/D commands cannot fire on release or auto-repeat.

## Interface
Parameters:
- `HELD_DEPTH`, 4: number of simultaneously held keys tracked for repeat suppression.
- `PREFIX_TIMEOUT`, 2_500_000: cycles (50 ms at 50 MHz) a prefix state may wait for its next byte before abandoning the sequence.

Ports:
- `CLOCK_50`  in  1: sole clock, all logic on rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `rx_data`  in  8: byte from `PS2_Controller` `received_data`.
- `rx_valid`  in  1: one-cycle strobe from `received_data_en`.
- `key_code`  out  8: scan code of the current event; holds its value between events.
- `key_ext`  out  1: event carried an `0xE0` prefix.
- `key_make`  out  1: one-cycle pulse, new key press.
- `key_break`  out  1: one-cycle pulse, key release.
- `held_count`  out  clog2(HELD_DEPTH+1): occupied held-table entries.
- `held_ovf`  out  1: sticky, a make arrived while the table was full; cleared only by reset.

## Operation
States:
- IDLE
- EXT (after `E0`)
- BRK (after `F0`)
- EXT_BRK (after `E0 F0`)
- SKIP (Pause sequence)

Byte handling in IDLE:
- `E0` -> EXT.
- `F0` -> BRK.
- `E1` -> SKIP, load skip counter with 7.
- `AA`, `FA`, `FE`, `EE`, `00`, `FF` -> dropped, stay in IDLE.
- Any other byte -> make event (ext=0).

Byte handling in prefix states:
- EXT: `F0` -> EXT_BRK; `E0` -> stay in EXT; any other byte -> make event (ext=1), go to IDLE.
- BRK: any byte -> break event (ext=0), go to IDLE.
- EXT_BRK: any byte -> break event (ext=1), go to IDLE.
- SKIP: each byte decrements the counter; at 0 -> IDLE. No event is emitted.

Timeout:
- Any state other than IDLE counts cycles without `rx_valid`.
- At `PREFIX_TIMEOUT` it returns to IDLE with no event.
- The counter reloads on every accepted byte.

Make event:
- The event is looked up in the held table by `{ext, code}`.
- Hit: typematic repeat, no pulse.
- Miss: emit `key_make`.
- On a miss with a free slot, insert into the lowest free slot.
- On a miss with the table full, do not insert; set `held_ovf`.

Break event:
- Emit `key_break` always.
- Invalidate the matching entry if present; no error if absent.

Key outputs:
- `key_code` and `key_ext` update on every emitted event.
- `key_make` and `key_break` are never high in the same cycle.

Reset values: state IDLE, table all invalid, `key_code` 0x00, `key_ext` 0, `key_make` 0, `key_break` 0, `held_count` 0, `held_ovf` 0, timeout counter 0.

## Timing
- `rx_valid` at cycle N -> `key_make` or `key_break` high in cycle N+1 only, with `key_code`/`key_ext` valid from N+1.
- Table lookup is combinational over `HELD_DEPTH` entries. The insert or invalidate is visible to a byte arriving at N+1.
- Back-to-back `rx_valid` on consecutive cycles must be handled, even though it cannot occur with the real controller.
- If `rx_valid` coincides with the timeout terminal count, the byte wins: it is processed in the current state.
- `resetn` asserted mid-sequence clears everything immediately. The first byte after release is parsed from IDLE.

## Configuration
`PS2_TYPEMATIC_SUPPRESS_EN`:
- Defined: the held table, `held_count` and `held_ovf` behave as above.
- Undefined:
  - No table is built.
  - Every make event pulses `key_make`, repeats included.
  - `held_count` is tied to 0 and `held_ovf` to 0.

## Structure
- Shared package `ps2_pkg`:
  - state enum;
  - prefix constants `PS2_EXT`=0xE0, `PS2_BRK`=0xF0, `PS2_PAUSE`=0xE1;
  - status-byte constants;
  - Pause skip length 7.
- One sub-module, `ps2_held_table`:
  - HELD_DEPTH valid/tag registers;
  - lookup hit output;
  - insert/remove ports;
  - count and full outputs.
- Instantiated only under `PS2_TYPEMATIC_SUPPRESS_EN`.

## Test plan
- Bytes `33`, `F0`, `33` -> `key_make` with code 0x33 ext 0 one cycle after the first byte; `key_break` with 0x33 one cycle after the third byte; `held_count` goes 1 then 0.
- Bytes `1B`, `1B`, `1B`, `F0`, `1B` -> exactly one `key_make` and one `key_break` (macro defined); with the macro undefined -> three `key_make` pulses.
- Bytes `E0`, `75`, `E0`, `F0`, `75` -> make then break with code 0x75 ext 1. A following plain `75` is a new make with ext 0.
- Bytes `E1 14 77 E1 F0 14 F0 77`, then `23` -> no events during the Pause sequence; `key_make` 0x23 after it.
- HELD_DEPTH=4: makes `23`, `33`, `1B`, `1C`, `2B` with no releases -> five `key_make` pulses; `held_count`=4; `held_ovf`=1 after `2B`.
- `F0`, then `PREFIX_TIMEOUT` idle cycles, then `23` -> no break; `key_make` 0x23. Separately, `resetn` pulsed after `E0` -> next byte `75` gives make with ext 0.
